// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the CPU control FSM.
// Latency: none (constants and a combinational helper only).
// Backpressure: not applicable.
package muldiv_pkg;

    // Operation encodings; the CPU control FSM drives op with these same values.
    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    // Sequencer state encoding.
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] CALC = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    // Conditional negation is done at a fixed wide width. Callers zero-extend
    // into it and truncate the result. Two's-complement negation truncated to
    // N bits equals negation at N bits, so this is exact for any 2*WIDTH <= 128.
    localparam int NEG_W = 128;
    typedef logic [NEG_W-1:0] neg_t;

    function automatic neg_t neg_if(input logic sel, input neg_t val);
        return sel ? -val : val;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restore-compare for divide.
// Latency: combinational, no state.
// Backpressure: none; the sequencer decides when the result is taken.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_nxt
);

    // Multiply: acc = {partial product high, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits / quotient bits so far}.
    // The divide remainder is always below the divisor, so it fits in WIDTH bits
    // between iterations. Only the shifted value needs the extra bit.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Compute both candidate iterations and pick one by mode.
    always_comb begin
        addend  = acc[0] ? opnd : '0;
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        fits    = rem_sh >= {1'b0, opnd};
        diff    = rem_sh[WIDTH-1:0] - opnd;
        if (is_div) begin
            acc_nxt = {(fits ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], fits};
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multicycle signed/unsigned multiply and divide producing HI/LO with a start/busy/done handshake.
// Latency: done WIDTH+3 cycles after accepted start (2 cycles for divide by zero).
// Backpressure: start ignored while busy, except in the done cycle where it is accepted back-to-back.
import muldiv_pkg::*;

module muldiv_seq #(
    parameter int WIDTH = 32,              // even, 4..64
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,        // asynchronous, active low
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             mult_overflow
);

    localparam int W2 = 2 * WIDTH;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    acc_nxt;
    logic [WIDTH-1:0] mag_b;
    logic             is_div;
    logic             is_sgn;
    logic             neg_res;   // product / quotient sign
    logic             neg_rem;   // remainder follows the dividend sign

    logic             accept;
    logic             sgn_op;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             zero_div;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // A request is taken when idle, or in the done cycle for back-to-back issue.
    assign accept   = start && ((state == IDLE) || (state == FIN));
    assign busy     = (state != IDLE);
    assign done     = (state == FIN);
    assign zero_div = is_div && (mag_b == '0);

    // Operand magnitudes and signs; the engine itself only sees unsigned values.
    always_comb begin
        sgn_op = ~op[0];
        sa     = sgn_op & a[WIDTH-1];
        sb     = sgn_op & b[WIDTH-1];
        abs_a  = sa ? -a : a;
        abs_b  = sb ? -b : b;
    end

    // Sign correction of the unsigned engine result, applied in FIX.
    always_comb begin
        prod_fix = W2'(neg_if(neg_res, neg_t'(acc)));
        quo_fix  = WIDTH'(neg_if(neg_res, neg_t'(acc[WIDTH-1:0])));
        rem_fix  = WIDTH'(neg_if(neg_rem, neg_t'(acc[W2-1:WIDTH])));
    end

    // Sequencer next-state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = zero_div ? FIN : CALC;
            CALC:    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = FIN;
            FIN:     state_nxt = start ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and iteration counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                cnt <= '0;
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc     (acc),
        .opnd    (mag_b),
        .acc_nxt (acc_nxt)
    );

    // Operand capture on acceptance, so a/b/op may change during the operation;
    // LOAD then only chooses between the iterative path and the divide-by-zero exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc     <= '0;
            mag_b   <= '0;
            is_div  <= 1'b0;
            is_sgn  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept) begin
            acc     <= {{WIDTH{1'b0}}, abs_a};
            mag_b   <= abs_b;
            is_div  <= op[1];
            is_sgn  <= sgn_op;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
        end else if (state == CALC) begin
            acc     <= acc_nxt;
        end
    end

    // Results update on the FIX->FIN edge; flags clear on acceptance and stay sticky.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi            <= '0;
            lo            <= '0;
            div_by_zero   <= 1'b0;
            mult_overflow <= 1'b0;
        end else if (accept) begin
            div_by_zero   <= 1'b0;
            mult_overflow <= 1'b0;
        end else if ((state == LOAD) && zero_div) begin
            div_by_zero   <= 1'b1;
        end else if (state == FIX) begin
            if (is_div) begin
                hi <= rem_fix;
                lo <= quo_fix;
            end else begin
                hi            <= prod_fix[W2-1:WIDTH];
                lo            <= prod_fix[WIDTH-1:0];
                mult_overflow <= is_sgn &&
                                 (prod_fix[W2-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
            end
        end
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Parametrised multicycle multiply/divide unit producing HI/LO results for the multicycle CPU datapath. It replaces the combinational Mult/Div pair with one iterative radix-2 engine behind a start/busy/done handshake. The control FSM stalls on `busy` and writes HI/LO on `done`. Signed and unsigned modes are selected per operation.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4 and even.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width; derived, never overridden.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a`  in  WIDTH  multiplicand / dividend (the A register), sampled with `start`.
- `b`  in  WIDTH  multiplier / divisor (the B register), sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done` inclusive.
- `done`  out  1  single-cycle pulse; `hi`/`lo`/flags are valid from this cycle on.
- `hi`  out  WIDTH  product upper half / remainder.
- `lo`  out  WIDTH  product lower half / quotient.
- `div_by_zero`  out  1  sticky until the next accepted `start`.
- `mult_overflow`  out  1  signed MULT: `hi` is not the sign extension of `lo[WIDTH-1]`; always 0 for MULTU. Sticky like `div_by_zero`.

## Operation
- One clock and one reset. The asynchronous reset is active-low.
- Reset values: state IDLE; `busy`, `done`, `div_by_zero`, `mult_overflow` = 0; `hi`, `lo` = 0; counter = 0.
- States:
  - IDLE → LOAD on `start`.
  - LOAD → CALC, or → FIN when a divide has `b`=0.
  - CALC → FIX after WIDTH iterations.
  - FIX → FIN.
  - FIN → IDLE.
- LOAD, signed ops: latch `|a|`, `|b|` and the result sign bits. Unsigned ops latch the raw operands. Clear both flags.
- CALC for multiply: shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- CALC for divide: restoring division, one quotient bit per cycle. Partial remainder is WIDTH+1 bits.
- FIX:
  - Negate the product if operand signs differ.
  - Negate the quotient if signs differ.
  - Remainder takes the sign of the dividend. Quotient truncates toward zero.
- Signed MIN / −1: `lo` = MIN, `hi` = 0, no flag.
- Divide by zero:
  - `hi`/`lo` keep their previous values.
  - `div_by_zero` = 1.
  - CALC and FIX are skipped.
- FIN: drive `done`=1. `hi`/`lo` update at the FIN entry edge.
- `start` while `busy` is ignored and not queued. `a`, `b` and `op` may change freely after acceptance.
- Reset asserted mid-operation aborts immediately to reset values. No partial result is visible.

## Timing
- Accepted `start` at edge E0. `busy` rises after E0, in the LOAD cycle.
- Normal op: LOAD 1 cycle + CALC WIDTH cycles + FIX 1 cycle + FIN 1 cycle. `done` is high in cycle WIDTH+3 after E0, which is 35 for WIDTH=32.
- Divide by zero: `done` in cycle 2 after E0.
- `busy` falls and IDLE is entered at the edge ending FIN. A new `start` may be presented in that same FIN cycle; it is accepted at the next edge (back-to-back).
- `hi`/`lo` hold until the next FIN.
- Throughput: one op per WIDTH+3 cycles.

## Structure
- Package `muldiv_pkg` holds:
  - the `op` encodings MULT/MULTU/DIV/DIVU;
  - the state enum (IDLE, LOAD, CALC, FIX, FIN);
  - the function `neg_if(sel, val)`.
  - The CPU control FSM imports the same `op` constants.
- Sub-module `muldiv_step` is combinational. It performs one iteration: an add-shift or subtract-compare on the accumulator/remainder, selected by mode. The FSM, counter and registers stay in `muldiv_seq`.
- Flags are registered. No combinational path runs from `a`/`b` to any output.

## Test plan
- MULTU `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` at cycle 35, `mult_overflow`=0.
- MULT `a`=−7, `b`=6 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFD6.
- MULT `a`=0x40000000, `b`=4 → `hi`=1, `lo`=0, `mult_overflow`=1.
- DIV `a`=−7, `b`=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
- DIVU `a`=100, `b`=7 → `lo`=14, `hi`=2.
- DIV MIN/−1 → `lo`=0x80000000, `hi`=0, no flags.
- DIVU `b`=0 after a prior result 14/2:
  - `done` at cycle 2, `div_by_zero`=1, `hi`/`lo` stay 2/14.
  - The next valid op clears the flag.
- Protocol cases:
  - `start` pulsed while `busy` → ignored, the first result is unaffected.
  - Back-to-back start in the FIN cycle is accepted.
  - `reset` low at CALC cycle 10 → all outputs 0 immediately, IDLE.
  - Rerun the MULTU and DIVU cases at WIDTH=8 and check results against the same arithmetic truncated to 8 bits.
